// File: rtl/console_input_arbiter_pkg.sv
// Shared types for the console input arbiter: sequencer states and ASCII helpers.
package console_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_BANNER,
      ST_RUN
   } state_t;

   typedef logic [7:0] ascii_t;

   localparam ascii_t ASCII_NUL = 8'h00;

endpackage

// File: rtl/console_input_arbiter_char_fifo.sv
// Show-ahead synchronous FIFO; a push while full is only taken when a pop frees a slot that cycle.
module char_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == DEPTH_CNT);
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/console_input_arbiter.sv
// Feeds vga_console's write port: banner string, buffered keyboard chars and clear commands,
// serialised with a minimum idle gap after every appended character.
//
//   state     | meaning
//   ST_CLEAR  | flush FIFO, issue one clear pulse, then banner (after reset / clear+banner) or run
//   ST_BANNER | emit non-NUL banner bytes in order, each followed by the char gap
//   ST_RUN    | drain keyboard FIFO at the gap-limited rate; honour banner requests
module console_input_arbiter
   import console_pkg::*;
#(
   parameter int                      FIFO_DEPTH = 16,
   parameter int                      BANNER_LEN = 16,
   parameter logic [BANNER_LEN*8-1:0] BANNER     = "Hello World!1234",
   parameter int                      CHAR_GAP   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          kbd_valid,
   input  logic                          kbd_pressed,
   input  logic [7:0]                    kbd_ascii,
   input  logic                          clear_req,
   input  logic                          banner_req,
   output logic [7:0]                    append_char,
   output logic                          clear,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [7:0]                    overflow_cnt
);

   localparam int         IW     = $clog2(BANNER_LEN + 1);
   localparam logic [3:0] GAP_LD = 4'(CHAR_GAP);

   state_t        state_q, state_d;
   ascii_t        append_q, append_d;
   logic          clear_q, clear_d;
   logic          busy_q, busy_d;
   logic [3:0]    gap_q, gap_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          banner_pend_q, banner_pend_d;
   logic [7:0]    ovf_q, ovf_d;

   logic          fifo_push, fifo_pop, fifo_flush;
   ascii_t        fifo_dout;
   logic          fifo_full, fifo_empty;
   logic          key_hit;

   logic          ban_found;
   logic [IW-1:0] ban_sel;
   ascii_t        ban_byte;

   char_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   (kbd_ascii),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign key_hit = kbd_valid & kbd_pressed & (kbd_ascii != ASCII_NUL);

   // First non-NUL byte at or after idx_q, so NULs cost no cycles.
   always_comb begin
      ban_found = 1'b0;
      ban_sel   = '0;
      ban_byte  = ASCII_NUL;
      for (int i = 0; i < BANNER_LEN; i++) begin
         if (!ban_found && (IW'(i) >= idx_q) &&
             (BANNER[(BANNER_LEN-i)*8-1 -: 8] != ASCII_NUL)) begin
            ban_found = 1'b1;
            ban_sel   = IW'(i);
            ban_byte  = BANNER[(BANNER_LEN-i)*8-1 -: 8];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      append_d      = ASCII_NUL;
      clear_d       = 1'b0;
      gap_d         = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
      idx_d         = idx_q;
      banner_pend_d = banner_pend_q;
      ovf_d         = ovf_q;
      fifo_pop      = 1'b0;
      fifo_flush    = 1'b0;
      fifo_push     = 1'b0;

      if (clear_req) begin
         state_d       = ST_CLEAR;
         gap_d         = 4'd0;
         banner_pend_d = banner_req;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clear_d       = 1'b1;
               fifo_flush    = 1'b1;
               idx_d         = '0;
               banner_pend_d = 1'b0;
               state_d       = banner_pend_q ? ST_BANNER : ST_RUN;
            end
            ST_BANNER: begin
               if (gap_q == 4'd0) begin
                  if (ban_found) begin
                     append_d = ban_byte;
                     idx_d    = ban_sel + 1'b1;
                     gap_d    = GAP_LD;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (gap_q == 4'd0 && (banner_pend_q || banner_req)) begin
                  state_d       = ST_BANNER;
                  idx_d         = '0;
                  banner_pend_d = 1'b0;
               end else begin
                  if (banner_req) banner_pend_d = 1'b1;
                  if (gap_q == 4'd0 && !fifo_empty) begin
                     fifo_pop = 1'b1;
                     append_d = fifo_dout;
                     gap_d    = GAP_LD;
                  end
               end
            end
            default: state_d = ST_CLEAR;
         endcase
      end

      // Keys arriving with a clear request or during the clear cycle are discarded silently.
      if (key_hit && !clear_req && state_q != ST_CLEAR) begin
         if (!fifo_full || fifo_pop) fifo_push = 1'b1;
         else if (ovf_q != 8'hFF)    ovf_d     = ovf_q + 8'd1;
      end

      busy_d = (state_d != ST_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_CLEAR;
         append_q      <= ASCII_NUL;
         clear_q       <= 1'b0;
         busy_q        <= 1'b1;
         gap_q         <= 4'd0;
         idx_q         <= '0;
         banner_pend_q <= 1'b1;
         ovf_q         <= 8'd0;
      end else begin
         state_q       <= state_d;
         append_q      <= append_d;
         clear_q       <= clear_d;
         busy_q        <= busy_d;
         gap_q         <= gap_d;
         idx_q         <= idx_d;
         banner_pend_q <= banner_pend_d;
         ovf_q         <= ovf_d;
      end
   end

   assign append_char  = append_q;
   assign clear        = clear_q;
   assign busy         = busy_q;
   assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_console_input_arbiter.sv
// Bench for console_input_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_console_input_arbiter;

   localparam int GAP   = 1;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       kbd_valid = 1'b0, kbd_pressed = 1'b0, clear_req = 1'b0, banner_req = 1'b0;
   logic [7:0] kbd_ascii = 8'h00;

   logic [7:0] append_char, overflow_cnt;
   logic       clear, busy;
   logic [4:0] fifo_count;

   logic [7:0] a2, ov2;
   logic       c2, b2;
   logic [4:0] fc2;

   always #5 clk = ~clk;

   console_input_arbiter dut (
      .clk(clk), .rst_n(rst_n), .kbd_valid(kbd_valid), .kbd_pressed(kbd_pressed),
      .kbd_ascii(kbd_ascii), .clear_req(clear_req), .banner_req(banner_req),
      .append_char(append_char), .clear(clear), .busy(busy),
      .fifo_count(fifo_count), .overflow_cnt(overflow_cnt)
   );

   console_input_arbiter #(
      .FIFO_DEPTH(16), .BANNER_LEN(16),
      .BANNER({"Hel", 8'h00, "o World!1234"}), .CHAR_GAP(0)
   ) dut_nul (
      .clk(clk), .rst_n(rst_n), .kbd_valid(1'b0), .kbd_pressed(1'b0),
      .kbd_ascii(8'h00), .clear_req(1'b0), .banner_req(1'b0),
      .append_char(a2), .clear(c2), .busy(b2),
      .fifo_count(fc2), .overflow_cnt(ov2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: character queue, gap count and a mode word.
   logic [127:0]   ban_str = "Hello World!1234";
   logic [119:0]   nul_exp = "Helo World!1234";
   string          m_mode;
   byte unsigned   m_q[$];
   int             m_gap, m_pos, m_ovf;
   bit             m_want;
   int             e_app, e_clr, e_busy;

   function automatic int ban_at(input int i);
      return int'(ban_str[(16-i)*8-1 -: 8]);
   endfunction

   task automatic model_reset();
      m_mode = "clear"; m_q.delete(); m_gap = 0; m_pos = 0; m_ovf = 0; m_want = 1'b1;
      e_app = 0; e_clr = 0; e_busy = 1;
   endtask

   task automatic model_step(input bit kv, input bit kp, input int ka, input bit cr, input bit br);
      int  ngap;
      int  found;
      bit  push;
      e_app = 0;
      e_clr = 0;
      push  = kv && kp && (ka != 0) && !cr && (m_mode != "clear");
      ngap  = (m_gap > 0) ? m_gap - 1 : 0;
      if (cr) begin
         m_mode = "clear"; m_want = br; ngap = 0;
      end else if (m_mode == "clear") begin
         e_clr = 1; m_q.delete(); m_pos = 0;
         m_mode = m_want ? "banner" : "run";
         m_want = 1'b0;
      end else if (m_mode == "banner") begin
         if (m_gap == 0) begin
            found = -1;
            for (int i = m_pos; i < 16; i++)
               if (found < 0 && ban_at(i) != 0) found = i;
            if (found >= 0) begin
               e_app = ban_at(found); m_pos = found + 1; ngap = GAP;
            end else m_mode = "run";
         end
      end else begin
         if (m_gap == 0 && (m_want || br)) begin
            m_mode = "banner"; m_pos = 0; m_want = 1'b0;
         end else begin
            if (br) m_want = 1'b1;
            if (m_gap == 0 && m_q.size() > 0) begin
               e_app = m_q.pop_front(); ngap = GAP;
            end
         end
      end
      if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(ka[7:0]);
         else if (m_ovf < 255)   m_ovf++;
      end
      m_gap  = ngap;
      e_busy = (m_mode != "run") ? 1 : 0;
   endtask

   task automatic check_all();
      chk("append_char",  append_char,  e_app);
      chk("clear",        clear,        e_clr);
      chk("busy",         busy,         e_busy);
      chk("fifo_count",   fifo_count,   m_q.size());
      chk("overflow_cnt", overflow_cnt, m_ovf);
   endtask

   int n = 0;
   int pc = 0;
   int clr_cnt = 0;
   int first_pulse = -1, last_pulse = -1, first_idle = -1;
   int ban_seen[$];
   int a2_log[64];
   int c2_log[64];

   task automatic cyc(input bit kv, input bit kp, input int ka, input bit cr, input bit br);
      kbd_valid = kv; kbd_pressed = kp; kbd_ascii = ka[7:0]; clear_req = cr; banner_req = br;
      @(posedge clk);
      #1;
      n++;
      model_step(kv, kp, ka, cr, br);
      check_all();
      if (append_char != 8'h00) pc++;
      if (clear) clr_cnt++;
      if (n < 64) begin
         a2_log[n] = int'(a2);
         c2_log[n] = int'(c2);
      end
   endtask

   initial begin
      int  wait_n;
      bit  burst;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      chk("nul_rst_busy",  b2,  1);
      chk("nul_rst_count", fc2, 0);
      chk("nul_rst_ovf",   ov2, 0);
      rst_n = 1'b1;

      // Power-up banner
      for (int i = 0; i < 40; i++) begin
         cyc(0, 0, 0, 0, 0);
         if (append_char != 8'h00) begin
            ban_seen.push_back(int'(append_char));
            if (first_pulse < 0) first_pulse = n;
            last_pulse = n;
         end
         if (!busy && first_idle < 0) first_idle = n;
      end
      chk("ban_pulses",    ban_seen.size(), 16);
      chk("ban_first_cyc", first_pulse, 2);
      chk("ban_last_cyc",  last_pulse, 32);
      chk("busy_drop_cyc", first_idle, 34);
      for (int i = 0; i < ban_seen.size() && i < 16; i++) chk("ban_byte", ban_seen[i], ban_at(i));

      // NUL-bearing banner, no gap
      chk("nul_clear_c1", c2_log[1], 1);
      for (int i = 0; i < 15; i++) chk("nul_byte", a2_log[2+i], int'(nul_exp[(15-i)*8-1 -: 8]));
      chk("nul_end", a2_log[17], 0);

      // Key latency and release filtering
      cyc(1, 1, 'h41, 0, 0);
      chk("lat_t1", append_char, 0);
      cyc(0, 0, 0, 0, 0);
      chk("lat_t2", append_char, 'h41);
      cyc(0, 0, 0, 0, 0);
      chk("lat_t3", append_char, 0);
      cyc(1, 0, 'h42, 0, 0);
      pc = 0;
      repeat (5) cyc(0, 0, 0, 0, 0);
      chk("release_ignored", pc, 0);

      // Clear+banner, then 20 keys during the banner (one stray banner_req)
      pc = 0; clr_cnt = 0;
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(1, 1, 'h61 + i, 0, (i == 10));
      repeat (90) cyc(0, 0, 0, 0, 0);
      chk("fill_pulses", pc, 32);
      chk("fill_clears", clr_cnt, 1);
      chk("fill_ovf",    overflow_cnt, 4);

      // Abort banner after byte 5 with a key in the request cycle
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0);
      pc = 0; wait_n = 0;
      while (pc < 6 && wait_n < 40) begin
         cyc(0, 0, 0, 0, 0);
         wait_n++;
      end
      chk("abort_reach_b5", pc, 6);
      pc = 0; clr_cnt = 0;
      cyc(1, 1, 'h5A, 1, 0);
      repeat (40) cyc(0, 0, 0, 0, 0);
      chk("abort_pulses", pc, 0);
      chk("abort_clears", clr_cnt, 1);
      chk("abort_count",  fifo_count, 0);
      chk("abort_busy",   busy, 0);

      // Random traffic
      burst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) burst = ($urandom_range(0, 1) == 1);
         cyc($urandom_range(0, 99) < (burst ? 90 : 20),
             $urandom_range(0, 9) < 8,
             ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255)),
             $urandom_range(0, 149) == 0,
             $urandom_range(0, 79) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
